// File: rtl/h264_pipeline_sequencer.sv
// Pipeline-enable sequencer for the H.264 core transform datapath: IDLE -> RUN (ROWS) -> TAIL (GAP).
// Optional stall support is compiled in with `define H264_SEQ_STALL_EN.
module h264_pipeline_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int ROWS       = 4,
    parameter int GAP        = 3
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic                  STALL,
    output logic [NUM_STAGES-1:0] en_pipeline,
    output logic                  READY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           BLK_COUNT
);

    localparam int CNT_MAX = (ROWS > GAP) ? ROWS : GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ROWS_LAST = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_act;

`ifdef H264_SEQ_STALL_EN
    // A stall only freezes an active block; in IDLE it must not block a start.
    assign stall_act = STALL && (state_q != IDLE);
`else
    logic unused_stall;
    assign unused_stall = STALL;
    assign stall_act    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_pipeline = '0;
        READY       = 1'b0;
        DONE        = 1'b0;
        BUSY        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                READY = 1'b1;
                if (ENABLE) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                en_pipeline[0] = 1'b1;
                for (int k = 1; k < NUM_STAGES; k++) begin
                    en_pipeline[k] = (cnt_q == CNT_W'(k));
                end
                if (cnt_q == ROWS_LAST) begin
                    state_d = TAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TAIL: begin
                if (cnt_q == GAP_LAST) begin
                    DONE    = 1'b1;
                    READY   = 1'b1;
                    state_d = ENABLE ? RUN : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (stall_act) begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            en_pipeline = '0;
            DONE        = 1'b0;
            READY       = 1'b0;
        end
    end

    // DONE is already stall-gated, so a frozen final TAIL cycle cannot count twice.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            BLK_COUNT <= '0;
        end else if (DONE) begin
            BLK_COUNT <= BLK_COUNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_h264_pipeline_sequencer.sv
// Directed bench for h264_pipeline_sequencer: default (4,4,3) instance plus a (3,8,2) instance.
// Stall expectations follow whether H264_SEQ_STALL_EN is defined.
module tb_h264_pipeline_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic        STALL;
    logic [3:0]  en_a;
    logic        ready_a, busy_a, done_a;
    logic [15:0] count_a;

    logic        enable_b;
    logic [2:0]  en_b;
    logic        ready_b, busy_b, done_b;
    logic [15:0] count_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_a [7];
    logic [2:0] exp_b [10];
    logic [3:0] exp_s [12];
    int         stall_done_cyc;

    always #5 CLK = ~CLK;

    h264_pipeline_sequencer #(.NUM_STAGES(4), .ROWS(4), .GAP(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .STALL(STALL),
        .en_pipeline(en_a), .READY(ready_a), .BUSY(busy_a), .DONE(done_a), .BLK_COUNT(count_a)
    );

    h264_pipeline_sequencer #(.NUM_STAGES(3), .ROWS(8), .GAP(2)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(enable_b), .STALL(1'b0),
        .en_pipeline(en_b), .READY(ready_b), .BUSY(busy_b), .DONE(done_b), .BLK_COUNT(count_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic settle;
        @(negedge CLK);
    endtask

    task automatic do_reset;
        RESET_N  = 1'b0;
        ENABLE   = 1'b0;
        enable_b = 1'b0;
        STALL    = 1'b0;
        step();
        RESET_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_a = '{4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        exp_b = '{3'b001, 3'b011, 3'b101, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
`ifdef H264_SEQ_STALL_EN
        exp_s = '{4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                  4'b0101, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        stall_done_cyc = 12;
`else
        exp_s = '{4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b0000, 4'b0000,
                  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        stall_done_cyc = 7;
`endif

        // Reset values
        RESET_N  = 1'b0;
        ENABLE   = 1'b0;
        enable_b = 1'b0;
        STALL    = 1'b0;
        #2;
        check("rst_en", en_a, 4'b0000);
        check("rst_ready", ready_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_count", count_a, 16'd0);
        step();
        RESET_N = 1'b1;

        // Single start with a one-cycle ENABLE pulse
        step();
        ENABLE = 1'b1;
        settle();
        check("single_ready_idle", ready_a, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step();
            ENABLE = 1'b0;
            settle();
            check($sformatf("single_en_c%0d", i), en_a, exp_a[i-1]);
            check($sformatf("single_done_c%0d", i), done_a, (i == 7));
            check($sformatf("single_ready_c%0d", i), ready_a, (i == 7));
            check($sformatf("single_busy_c%0d", i), busy_a, 1'b1);
        end
        check("single_count_at_done", count_a, 16'd0);
        step();
        settle();
        check("single_count_after", count_a, 16'd1);
        check("single_ready_after", ready_a, 1'b1);
        check("single_busy_after", busy_a, 1'b0);

        // ENABLE held high: three back-to-back blocks
        do_reset();
        ENABLE = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            step();
            if (i == 21) ENABLE = 1'b0;
            settle();
            check($sformatf("b2b_en_c%0d", i), en_a, exp_a[(i-1) % 7]);
            check($sformatf("b2b_done_c%0d", i), done_a, (i % 7 == 0));
            check($sformatf("b2b_busy_c%0d", i), busy_a, 1'b1);
        end
        step();
        settle();
        check("b2b_count", count_a, 16'd3);
        check("b2b_busy_end", busy_a, 1'b0);

        // Asynchronous reset on RUN cycle 3 (count was 3 before)
        step();
        ENABLE = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            ENABLE = 1'b0;
            settle();
        end
        check("abort_pre_en", en_a, 4'b0101);
        RESET_N = 1'b0;
        #1;
        check("abort_en", en_a, 4'b0000);
        check("abort_busy", busy_a, 1'b0);
        check("abort_ready", ready_a, 1'b1);
        check("abort_done", done_a, 1'b0);
        check("abort_count", count_a, 16'd0);
        step();
        RESET_N = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            settle();
            check($sformatf("abort_nodone_c%0d", i), done_a, 1'b0);
        end
        check("abort_count_after", count_a, 16'd0);

        // Second configuration: NUM_STAGES=3, ROWS=8, GAP=2
        do_reset();
        enable_b = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            enable_b = 1'b0;
            settle();
            check($sformatf("cfg_b_en_c%0d", i), en_b, exp_b[i-1]);
            check($sformatf("cfg_b_done_c%0d", i), done_b, (i == 10));
        end
        step();
        settle();
        check("cfg_b_count", count_b, 16'd1);
        check("cfg_b_ready", ready_b, 1'b1);

        // STALL: ignored in IDLE; with the feature on, 5 stall cycles at RUN cnt=2
        do_reset();
        ENABLE = 1'b1;
        STALL  = 1'b1;
        settle();
        check("stall_idle_ready", ready_a, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step();
            ENABLE = 1'b0;
            STALL  = (i >= 3 && i <= 7);
            settle();
            check($sformatf("stall_en_c%0d", i), en_a, exp_s[i-1]);
            check($sformatf("stall_done_c%0d", i), done_a, (i == stall_done_cyc));
        end
        STALL = 1'b0;
        step();
        settle();
        check("stall_count", count_a, 16'd1);

        // BLK_COUNT wrap from 0xFFFF
        force dut.BLK_COUNT = 16'hFFFF;
        #1;
        release dut.BLK_COUNT;
        #1;
        check("wrap_preload", count_a, 16'hFFFF);
        step();
        ENABLE = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            ENABLE = 1'b0;
        end
        settle();
        check("wrap_done", done_a, 1'b1);
        step();
        settle();
        check("wrap_count", count_a, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/h264_pipeline_sequencer.md
# h264_pipeline_sequencer

Parametrised pipeline-enable sequencer for the H.264 core transform datapath. It generalises the fixed eight-state transform controller to any stage count, row count and tail length. It adds a ready/done handshake, back-to-back block starts, a completed-block counter and an optional stall. It sits between the macroblock scheduler and the transform pipeline registers, and produces one enable per pipeline stage.

## Interface
- NUM_STAGES, 4: number of pipeline-stage enables; legal range 2..ROWS.
- ROWS, 4: load cycles per 4x4 block (run length); legal range 2..16.
- GAP, 3: flush cycles after the run before the next block may start; legal range 1..16.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET_N  input  1  reset; asynchronous, active-low.
- ENABLE  input  1  block start request; sampled only while READY=1.
- STALL  input  1  freeze request; functional only with H264_SEQ_STALL_EN.
- en_pipeline  output  NUM_STAGES  per-stage enables; bit 0 is the first pipeline stage.
- READY  output  1  high when a start on ENABLE will be accepted this cycle.
- BUSY  output  1  high in RUN or TAIL.
- DONE  output  1  one-cycle pulse in the final TAIL cycle of each block.
- BLK_COUNT  output  16  number of completed blocks; wraps 0xFFFF->0x0000.

## Operation
- States: IDLE, RUN, TAIL. Cycle counter cnt, width $clog2(max(ROWS,GAP)).
- IDLE: all enables 0. ENABLE=1 moves the block to RUN with cnt=0. ENABLE=0 keeps it in IDLE; no undefined next state.
- RUN, cnt = 0..ROWS-1:
  - en_pipeline[0]=1 in every RUN cycle.
  - en_pipeline[k], for k = 1..NUM_STAGES-1, is 1 only when cnt==k.
  - When cnt==ROWS-1, the block moves to TAIL with cnt=0.
- TAIL, cnt = 0..GAP-1:
  - All enables are 0.
  - At cnt==GAP-1: DONE=1, READY=1, and BLK_COUNT increments on the following edge.
  - In that cycle, ENABLE=1 moves directly to RUN cnt=0 (back-to-back start); ENABLE=0 moves to IDLE.
- READY = IDLE, or TAIL with cnt==GAP-1, and not stalled.
- BUSY = RUN or TAIL.
- ENABLE outside READY is ignored; requests are not queued.
- All outputs are Moore, decoded from registered state and cnt, except for the STALL gating below.

## Timing
- Reset values: state IDLE, cnt 0, en_pipeline 0, DONE 0, BUSY 0, READY 1, BLK_COUNT 0.
- Reset takes effect immediately, including mid-block. Enables drop in the same cycle and no DONE is produced for the aborted block.
- Start latency: ENABLE is sampled high at edge t. en_pipeline[0] is high for cycles t+1 .. t+ROWS.
- Block period: ROWS+GAP cycles. Back-to-back starts give a sustained throughput of one block per ROWS+GAP cycles with no idle cycle.
- Default sequence (4,4,3), per cycle after the start: en = 0001, 0011, 0101, 1001, then 0000 x3. DONE is high in the third zero cycle.
- DONE and BLK_COUNT: BLK_COUNT updates one cycle after DONE. DONE is never asserted twice for one block.

## Configuration
- H264_SEQ_STALL_EN defined:
  - STALL=1 in RUN or TAIL holds state and cnt, and forces en_pipeline, DONE and READY to 0.
  - The sequence resumes exactly where it stopped on the first cycle STALL=0.
  - STALL in IDLE has no effect.
  - STALL and ENABLE together in the final TAIL cycle do not start a block.
- H264_SEQ_STALL_EN undefined: the STALL port exists but is ignored, and behaviour is identical to STALL tied 0.

## Test plan
- Reset then single start (defaults): ENABLE pulsed for one cycle. Expect en = 0001, 0011, 0101, 1001, 0000, 0000, 0000. DONE is high on cycle 7 only, then BLK_COUNT=1 and READY=1.
- ENABLE held high continuously for three blocks: no idle cycle between blocks, DONE every 7 cycles, BLK_COUNT=3. ENABLE in non-ready cycles does not restart the block.
- NUM_STAGES=3, ROWS=8, GAP=2: en[0] high for 8 cycles, en[1] on cycle 2, en[2] on cycle 3. DONE on cycle 10.
- RESET_N dropped on RUN cycle 3: outputs go to reset values asynchronously. BLK_COUNT stays 0 and no DONE occurs.
- With H264_SEQ_STALL_EN: STALL high for 5 cycles at RUN cnt=2. Enables are 0 during the stall, then the sequence resumes with en=0101 and DONE is delayed by exactly 5 cycles.
- BLK_COUNT preloaded via force to 0xFFFF, one block run: it wraps to 0x0000.
